breakout_input_cond: RTL and testbench

- Conditions the raw breakout-board inputs (digital port, pushbuttons, link-power flags) before the serializer latches them into a frame.
- Synchronizes every asynchronous input into the serializer clock domain and debounces the buttons.
- Stretches short button presses so a press is never lost between two serializer frame samples.
- Sits directly upstream of the breakout-to-host serializer and drives its i_port, i_button and i_link_pow inputs.

---
 rtl/breakout_input_cond_pkg.sv | 22 ++
 rtl/breakout_input_cond_debounce_bit.sv | 70 +++++++
 rtl/breakout_input_cond.sv | 80 ++++++++
 tb/tb_breakout_input_cond.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_input_cond_pkg.sv
// Shared widths, defaults and helpers for the breakout input conditioner.
package breakout_input_cond_pkg;

  localparam int unsigned PortW                 = 8;
  localparam int unsigned ButtonW               = 6;
  localparam int unsigned LinkPowW              = 4;
  localparam int unsigned DefaultDebounceCycles = 65536;

  // Bits needed to hold values 0..value-1 (value >= 2).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/breakout_input_cond_debounce_bit.sv
// One pushbutton: input synchronizer, stable-count debouncer and press stretcher.
module breakout_input_cond_debounce_bit
  import breakout_input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter bit          INVERT          = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic frame_tick_i,
  output logic deb_o,
  output logic pend_o
);

  localparam int unsigned         CntW   = clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]     CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   pend_q, pend_d;
  logic                   toggle;
  logic                   rise;

  // Next-state: shift the synchronizer, count disagreeing cycles, stretch presses.
  always_comb begin
    // Polarity is fixed before the first flop so the chain always carries 1 = pressed.
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i ^ INVERT};
    cnt_d  = '0;
    deb_d  = deb_q;
    toggle = 1'b0;
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == CntMax) begin
        toggle = 1'b1;
        deb_d  = ~deb_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    rise   = toggle & ~deb_q;
    // A new press beats a same-cycle frame tick so it is never dropped.
    pend_d = pend_q;
    if (rise) begin
      pend_d = 1'b1;
    end else if (frame_tick_i) begin
      pend_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      pend_q <= pend_d;
    end
  end

  assign deb_o  = deb_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/breakout_input_cond.sv
// Conditions raw breakout inputs (port, buttons, link power) for the frame serializer.
module breakout_input_cond
  import breakout_input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DefaultDebounceCycles,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PortW-1:0]    i_port_raw,
  input  logic [ButtonW-1:0]  i_button_raw,
  input  logic [LinkPowW-1:0] i_link_pow_raw,
  input  logic                i_frame_tick,
  output logic [PortW-1:0]    o_port,
  output logic [ButtonW-1:0]  o_button,
  output logic [LinkPowW-1:0] o_link_pow,
  output logic                o_button_event
);

  logic [SYNC_STAGES-1:0][PortW-1:0]    port_sync_q, port_sync_d;
  logic [SYNC_STAGES-1:0][LinkPowW-1:0] lp_sync_q, lp_sync_d;
  logic [ButtonW-1:0]                   button_q, button_d;
  logic [ButtonW-1:0]                   deb_prev_q, deb_prev_d;
  logic                                 event_q, event_d;
  logic [ButtonW-1:0]                   deb;
  logic [ButtonW-1:0]                   pend;

  for (genvar g = 0; g < ButtonW; g++) begin : g_button
    breakout_input_cond_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (BUTTON_ACTIVE_LOW)
    ) u_debounce_bit (
      .clk_i        (i_clk),
      .rst_i        (i_rst),
      .raw_i        (i_button_raw[g]),
      .frame_tick_i (i_frame_tick),
      .deb_o        (deb[g]),
      .pend_o       (pend[g])
    );
  end

  // Next-state: plain synchronizer chains plus registered button view and change pulse.
  always_comb begin
    port_sync_d[0] = i_port_raw;
    lp_sync_d[0]   = i_link_pow_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      port_sync_d[i] = port_sync_q[i-1];
      lp_sync_d[i]   = lp_sync_q[i-1];
    end
    button_d   = deb | pend;
    deb_prev_d = deb;
    // Lines up with the o_button update that reflects the same deb change.
    event_d    = |(deb ^ deb_prev_q);
  end

  // Output and synchronizer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      port_sync_q <= '0;
      lp_sync_q   <= '0;
      button_q    <= '0;
      deb_prev_q  <= '0;
      event_q     <= 1'b0;
    end else begin
      port_sync_q <= port_sync_d;
      lp_sync_q   <= lp_sync_d;
      button_q    <= button_d;
      deb_prev_q  <= deb_prev_d;
      event_q     <= event_d;
    end
  end

  assign o_port         = port_sync_q[SYNC_STAGES-1];
  assign o_link_pow     = lp_sync_q[SYNC_STAGES-1];
  assign o_button       = button_q;
  assign o_button_event = event_q;

endmodule

// File: tb/tb_breakout_input_cond.sv
// Directed and randomized bench for breakout_input_cond against a behavioural model.
module tb_breakout_input_cond;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_port_raw;
  logic [5:0] i_button_raw;
  logic [3:0] i_link_pow_raw;
  logic       i_frame_tick;
  logic [7:0] o_port;
  logic [5:0] o_button;
  logic [3:0] o_link_pow;
  logic       o_button_event;

  always #5 clk = ~clk;

  breakout_input_cond #(
    .SYNC_STAGES       (S),
    .DEBOUNCE_CYCLES   (D),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_port_raw     (i_port_raw),
    .i_button_raw   (i_button_raw),
    .i_link_pow_raw (i_link_pow_raw),
    .i_frame_tick   (i_frame_tick),
    .o_port         (o_port),
    .o_button       (o_button),
    .o_link_pow     (o_link_pow),
    .o_button_event (o_button_event)
  );

  int checks = 0;
  int errors = 0;

  // Current stimulus
  logic       cur_rst  = 1'b1;
  logic [7:0] cur_port = 8'hFF;
  logic [5:0] cur_btn  = 6'h3F;
  logic [3:0] cur_lp   = 4'hF;
  logic       cur_ft   = 1'b0;

  // Behavioural model: delay lines of sampled inputs, a window of the last D
  // synchronized button samples, and the pressed/pending/event state.
  logic [7:0] port_line [S];
  logic [3:0] lp_line   [S];
  logic [5:0] btn_line  [S];
  logic [5:0] shist [$];
  logic [5:0] m_deb, m_pend, m_btn;
  logic       m_evt, m_tog;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic [7:0] p, input logic [5:0] b,
                              input logic [3:0] l, input logic f);
    logic [5:0] tog;
    logic       all_diff;
    if (r) begin
      for (int i = 0; i < S; i++) begin
        port_line[i] = '0;
        lp_line[i]   = '0;
        btn_line[i]  = '0;
      end
      shist.delete();
      m_deb = '0; m_pend = '0; m_btn = '0; m_evt = 1'b0; m_tog = 1'b0;
    end else begin
      m_btn = m_deb | m_pend;
      m_evt = m_tog;
      shist.push_back(btn_line[S-1]);
      if (shist.size() > D) void'(shist.pop_front());
      tog = '0;
      if (shist.size() == D) begin
        for (int bi = 0; bi < 6; bi++) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++) if (shist[k][bi] == m_deb[bi]) all_diff = 1'b0;
          tog[bi] = all_diff;
        end
      end
      m_pend = (tog & ~m_deb) | (f ? 6'b0 : m_pend);
      m_deb  = m_deb ^ tog;
      m_tog  = |tog;
      for (int i = S - 1; i > 0; i--) begin
        port_line[i] = port_line[i-1];
        lp_line[i]   = lp_line[i-1];
        btn_line[i]  = btn_line[i-1];
      end
      port_line[0] = p;
      lp_line[0]   = l;
      btn_line[0]  = ~b;
    end
  endtask

  // One clock: drive on negedge, advance model on posedge, compare just after.
  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      i_rst          = cur_rst;
      i_port_raw     = cur_port;
      i_button_raw   = cur_btn;
      i_link_pow_raw = cur_lp;
      i_frame_tick   = cur_ft;
      @(posedge clk);
      model_update(cur_rst, cur_port, cur_btn, cur_lp, cur_ft);
      #1;
      check("port", 32'(o_port), 32'(port_line[S-1]));
      check("link_pow", 32'(o_link_pow), 32'(lp_line[S-1]));
      check("button", 32'(o_button), 32'(m_btn));
      check("event", 32'(o_button_event), 32'(m_evt));
    end
  endtask

  // Steps until o_button[bit] rises (bounded); returns edge count and event pulses.
  task automatic measure_rise(input int bi, output int lat, output int evts);
    lat  = -1;
    evts = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      if (o_button_event) evts++;
      if (lat < 0 && o_button[bi]) lat = i + 1;
    end
  endtask

  int lat, evts;

  initial begin
    i_rst = 1'b1; i_port_raw = '1; i_button_raw = '1; i_link_pow_raw = '1; i_frame_tick = 1'b0;

    // Reset with every raw input high
    cyc(3);
    check("rst_port", 32'(o_port), 32'h0);
    check("rst_button", 32'(o_button), 32'h0);
    check("rst_link_pow", 32'(o_link_pow), 32'h0);
    check("rst_event", 32'(o_button_event), 32'h0);

    // Port value appears two edges after release
    cur_rst = 1'b0;
    cyc(1);
    check("port_edge1", 32'(o_port), 32'h0);
    cyc(1);
    check("port_edge2", 32'(o_port), 32'hFF);
    check("link_pow_edge2", 32'(o_link_pow), 32'hF);
    check("released_buttons", 32'(o_button), 32'h0);
    cyc(4);

    // Clean press of button 3
    cur_btn[3] = 1'b0;
    measure_rise(3, lat, evts);
    check("press_latency", 32'(lat), 32'd7);
    check("press_events", 32'(evts), 32'd1);
    cur_ft = 1'b1; cyc(1); cur_ft = 1'b0;

    // Bouncing button 0
    cur_btn[0] = 1'b0; cyc(2);
    cur_btn[0] = 1'b1; cyc(2);
    cur_btn[0] = 1'b0;
    measure_rise(0, lat, evts);
    check("bounce_latency", 32'(lat), 32'd7);
    check("bounce_events", 32'(evts), 32'd1);

    // Release everything and let it settle
    cur_btn = 6'h3F; cyc(10);
    cur_ft = 1'b1; cyc(1); cur_ft = 1'b0;
    cyc(3);
    check("all_released", 32'(o_button), 32'h0);

    // Short press on button 5 held only until frame tick
    cur_btn[5] = 1'b0; cyc(6);
    cur_btn[5] = 1'b1; cyc(15);
    check("short_held", 32'(o_button[5]), 32'h1);
    cur_ft = 1'b1; cyc(1); cur_ft = 1'b0;
    check("short_tick_edge", 32'(o_button[5]), 32'h1);
    cyc(1);
    check("short_after_tick", 32'(o_button[5]), 32'h0);
    cyc(3);

    // deb[1] rises on the same edge as a frame tick
    cur_btn[1] = 1'b0; cyc(5);
    cur_ft = 1'b1; cyc(1); cur_ft = 1'b0;
    cur_btn[1] = 1'b1;
    cyc(10);
    check("same_cycle_pend", 32'(o_button[1]), 32'h1);
    cur_ft = 1'b1; cyc(1); cur_ft = 1'b0;
    check("same_cycle_tick", 32'(o_button[1]), 32'h1);
    cyc(1);
    check("same_cycle_clear", 32'(o_button[1]), 32'h0);
    cyc(3);

    // Reset in the middle of a debounce count, button held throughout
    cur_btn[2] = 1'b0; cyc(4);
    cur_rst = 1'b1; cyc(1);
    check("mid_rst_button", 32'(o_button), 32'h0);
    cur_rst = 1'b0;
    measure_rise(2, lat, evts);
    check("requalify_latency", 32'(lat), 32'd7);
    check("requalify_events", 32'(evts), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cur_port = 8'($urandom);
      cur_lp   = 4'($urandom);
      cur_btn  = cur_btn ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      cur_ft   = ($urandom_range(0, 7) == 0);
      cur_rst  = ($urandom_range(0, 149) == 0);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
